vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock, using a divide-by-2 pixel enable.
- Produces hsync/vsync plus the scaled 160x120 game coordinates (xvga/yvga) consumed by the pong `system` block and its renderer.
- Sits directly upstream of `system`; replaces the bench-modelled 40 ns coordinate sweep.
- Also produces a one-clock frame_start pulse that can pace game-state updates.

---
 rtl/vga_timing_gen_if.sv | 24 ++
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Bundle of VGA timing signals between the timing generator and its consumers.
// The generator owns every signal except enable, which its consumer drives.
interface vga_timing_gen_if;
  logic       enable;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [7:0] xvga;
  logic [7:0] yvga;
  logic       pix_en;
  logic       frame_start;

  modport master (
    input  enable,
    output hcount, vcount, hsync, vsync, video_on, xvga, yvga, pix_en, frame_start
  );

  modport slave (
    output enable,
    input  hcount, vcount, hsync, vsync, video_on, xvga, yvga, pix_en, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing with a pixel-rate enable derived from the system clock.
// Also provides game-resolution coordinates and a one-clock frame_start pulse.
module vga_timing_gen #(
  parameter int CLK_DIV     = 2,
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_timing_gen_if.master      vga
);

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [2:0] div_q, div_d;
  logic       run_q;
  logic [9:0] hCount_q, hCount_d;
  logic [9:0] vCount_q, vCount_d;
  logic       hsync_q, vsync_q, videoOn_q, frameStart_q;
  logic [7:0] xvga_q, yvga_q;
  logic       pixEn, lineEnd, frameEnd, visibleNext;
  logic [7:0] xNext, yNext;

  // Next-state counters; outputs are derived from these so they line up with the counters.
  always_comb begin
    div_d    = div_q;
    hCount_d = hCount_q;
    vCount_d = vCount_q;
    lineEnd  = (hCount_q == 10'(H_TOTAL - 1));
    frameEnd = lineEnd && (vCount_q == 10'(V_TOTAL - 1));
    // run_q keeps a divide-by-1 generator from strobing while still in reset.
    pixEn    = vga.enable && run_q && (div_q == 3'(CLK_DIV - 1));

    if (vga.enable) begin
      div_d = (div_q == 3'(CLK_DIV - 1)) ? 3'd0 : div_q + 3'd1;
    end

    if (pixEn) begin
      hCount_d = lineEnd ? 10'd0 : hCount_q + 10'd1;
      if (lineEnd) begin
        vCount_d = frameEnd ? 10'd0 : vCount_q + 10'd1;
      end
    end

    visibleNext = (hCount_d < 10'(H_VISIBLE)) && (vCount_d < 10'(V_VISIBLE));
    xNext       = visibleNext ? 8'(hCount_d >> SCALE_SHIFT) : 8'd0;
    yNext       = visibleNext ? 8'(vCount_d >> SCALE_SHIFT) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= 3'd0;
      run_q        <= 1'b0;
      hCount_q     <= 10'd0;
      vCount_q     <= 10'd0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      videoOn_q    <= 1'b1;
      xvga_q       <= 8'd0;
      yvga_q       <= 8'd0;
      frameStart_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      run_q        <= 1'b1;
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      hsync_q      <= !((hCount_d >= 10'(H_SYNC_START)) && (hCount_d < 10'(H_SYNC_END)));
      vsync_q      <= !((vCount_d >= 10'(V_SYNC_START)) && (vCount_d < 10'(V_SYNC_END)));
      videoOn_q    <= visibleNext;
      xvga_q       <= xNext;
      yvga_q       <= yNext;
      frameStart_q <= pixEn && frameEnd;
    end
  end

  assign vga.hcount      = hCount_q;
  assign vga.vcount      = vCount_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = videoOn_q;
  assign vga.xvga        = xvga_q;
  assign vga.yvga        = yvga_q;
  assign vga.pix_en      = pixEn;
  assign vga.frame_start = frameStart_q && vga.enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size divide-by-2 instance for line timing and a
// shrunken divide-by-1 instance so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int SIG_H  = 0;
  localparam int SIG_V  = 1;
  localparam int SIG_HS = 2;
  localparam int SIG_VS = 3;
  localparam int SIG_VO = 4;
  localparam int SIG_X  = 5;
  localparam int SIG_Y  = 6;
  localparam int SIG_PE = 7;
  localparam int SIG_FS = 8;

  typedef struct {
    int    at;
    int    dut;
    int    sig;
    int    val;
    string name;
  } expItem_t;

  logic clk;
  logic rstA, rstB;
  int   cyc;
  int   checks;
  int   errors;
  int   monIdx;
  int   actual;
  int   bA, bA2, bB;
  expItem_t sb[$];

  vga_timing_gen_if vifA ();
  vga_timing_gen_if vifB ();

  vga_timing_gen dutA (
    .clk   (clk),
    .rst_n (rstA),
    .vga   (vifA)
  );

  vga_timing_gen #(
    .CLK_DIV     (1),
    .H_VISIBLE   (16),
    .H_FRONT     (2),
    .H_SYNC      (4),
    .H_BACK      (2),
    .V_VISIBLE   (12),
    .V_FRONT     (2),
    .V_SYNC      (2),
    .V_BACK      (3),
    .SCALE_SHIFT (2)
  ) dutB (
    .clk   (clk),
    .rst_n (rstB),
    .vga   (vifB)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sampleSig(input int dut, input int sig);
    int r;
    r = -1;
    if (dut == 0) begin
      case (sig)
        SIG_H:  r = int'(vifA.hcount);
        SIG_V:  r = int'(vifA.vcount);
        SIG_HS: r = int'(vifA.hsync);
        SIG_VS: r = int'(vifA.vsync);
        SIG_VO: r = int'(vifA.video_on);
        SIG_X:  r = int'(vifA.xvga);
        SIG_Y:  r = int'(vifA.yvga);
        SIG_PE: r = int'(vifA.pix_en);
        SIG_FS: r = int'(vifA.frame_start);
        default: r = -1;
      endcase
    end else begin
      case (sig)
        SIG_H:  r = int'(vifB.hcount);
        SIG_V:  r = int'(vifB.vcount);
        SIG_HS: r = int'(vifB.hsync);
        SIG_VS: r = int'(vifB.vsync);
        SIG_VO: r = int'(vifB.video_on);
        SIG_X:  r = int'(vifB.xvga);
        SIG_Y:  r = int'(vifB.yvga);
        SIG_PE: r = int'(vifB.pix_en);
        SIG_FS: r = int'(vifB.frame_start);
        default: r = -1;
      endcase
    end
    return r;
  endfunction

  // Monitor: at each falling edge, settle every expectation scheduled for this cycle.
  always @(negedge clk) begin
    monIdx = 0;
    while (monIdx < sb.size()) begin
      if (sb[monIdx].at == cyc) begin
        checkOutput(sb[monIdx]);
        sb.delete(monIdx);
      end else if (sb[monIdx].at < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s: not sampled, scheduled cycle %0d, now %0d",
                 sb[monIdx].name, sb[monIdx].at, cyc);
        sb.delete(monIdx);
      end else begin
        monIdx++;
      end
    end
  end

  task automatic checkOutput(input expItem_t e);
    actual = sampleSig(e.dut, e.sig);
    checks++;
    if (actual != e.val) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, actual, e.val, cyc);
    end
  endtask

  task automatic pushExp(input int dut, input int at, input int sig, input int val, input string name);
    expItem_t e;
    e.at   = at;
    e.dut  = dut;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic pushResetState(input int dut, input int at, input string tag);
    pushExp(dut, at, SIG_H,  0, {tag, "_hcount"});
    pushExp(dut, at, SIG_V,  0, {tag, "_vcount"});
    pushExp(dut, at, SIG_HS, 1, {tag, "_hsync"});
    pushExp(dut, at, SIG_VS, 1, {tag, "_vsync"});
    pushExp(dut, at, SIG_VO, 1, {tag, "_video_on"});
    pushExp(dut, at, SIG_X,  0, {tag, "_xvga"});
    pushExp(dut, at, SIG_Y,  0, {tag, "_yvga"});
    pushExp(dut, at, SIG_PE, 0, {tag, "_pix_en"});
    pushExp(dut, at, SIG_FS, 0, {tag, "_frame_start"});
  endtask

  task automatic tickTo(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Stimulus: drive 2 ns after the rising edge, schedule hand-computed expectations ahead.
  task automatic applyStimulus();
    rstA = 1'b0;
    rstB = 1'b0;
    vifA.enable = 1'b1;
    vifB.enable = 1'b1;
    pushResetState(0, 2, "A_reset");
    tickTo(3);
    rstA = 1'b1;
    bA = cyc;

    // Before the enable pause, pixel index is (cycles since release)/2.
    pushExp(0, bA + 1,     SIG_PE, 1,   "A_first_pix_en");
    pushExp(0, bA + 1,     SIG_H,  0,   "A_h_before_first_step");
    pushExp(0, bA + 2,     SIG_PE, 0,   "A_pix_en_gap");
    pushExp(0, bA + 2,     SIG_H,  1,   "A_h_first_step");
    pushExp(0, bA + 3,     SIG_PE, 1,   "A_pix_en_second");
    pushExp(0, bA + 8,     SIG_X,  1,   "A_x_at_h4");
    pushExp(0, bA + 1279,  SIG_VO, 1,   "A_video_h639");
    pushExp(0, bA + 1279,  SIG_X,  159, "A_x_h639");
    pushExp(0, bA + 1280,  SIG_VO, 0,   "A_video_h640");
    pushExp(0, bA + 1280,  SIG_X,  0,   "A_x_h640");
    pushExp(0, bA + 1310,  SIG_HS, 1,   "A_hsync_h655");
    pushExp(0, bA + 1312,  SIG_H,  656, "A_h656");
    pushExp(0, bA + 1312,  SIG_HS, 0,   "A_hsync_h656");
    pushExp(0, bA + 1400,  SIG_X,  0,   "A_x_h700");
    pushExp(0, bA + 1503,  SIG_HS, 0,   "A_hsync_h751");
    pushExp(0, bA + 1504,  SIG_HS, 1,   "A_hsync_h752");
    pushExp(0, bA + 1599,  SIG_H,  799, "A_h799");
    pushExp(0, bA + 1599,  SIG_V,  0,   "A_v_before_wrap");
    pushExp(0, bA + 1600,  SIG_H,  0,   "A_h_wrap");
    pushExp(0, bA + 1600,  SIG_V,  1,   "A_v_after_wrap");
    pushExp(0, bA + 1600,  SIG_FS, 0,   "A_no_frame_start_line_wrap");
    pushExp(0, bA + 12808, SIG_V,  8,   "A_v8");
    pushExp(0, bA + 12808, SIG_X,  1,   "A_x_4_8");
    pushExp(0, bA + 12808, SIG_Y,  2,   "A_y_4_8");
    pushExp(0, bA + 14079, SIG_X,  159, "A_x_639_8");
    pushExp(0, bA + 14079, SIG_Y,  2,   "A_y_639_8");
    pushExp(0, bA + 15000, SIG_H,  300, "A_h300");
    pushExp(0, bA + 15001, SIG_PE, 0,   "A_pause_pix_en_forced");
    pushExp(0, bA + 15001, SIG_H,  300, "A_pause_h_start");
    pushExp(0, bA + 15030, SIG_H,  300, "A_pause_h_mid");
    pushExp(0, bA + 15030, SIG_FS, 0,   "A_pause_frame_start");
    pushExp(0, bA + 15051, SIG_PE, 1,   "A_resume_pix_en");
    pushExp(0, bA + 15051, SIG_H,  300, "A_resume_h_held");
    pushExp(0, bA + 15052, SIG_H,  301, "A_resume_h301");
    pushExp(0, bA + 15054, SIG_H,  302, "A_resume_h302");
    pushExp(0, bA + 15850, SIG_H,  700, "A_h700_line9");
    pushExp(0, bA + 15850, SIG_V,  9,   "A_v9");
    pushExp(0, bA + 15850, SIG_HS, 0,   "A_hsync_before_reset");
    pushExp(0, bA + 15850, SIG_VO, 0,   "A_video_before_reset");
    pushResetState(0, bA + 15851, "A_midline_reset");

    tickTo(bA + 15001);
    vifA.enable = 1'b0;
    tickTo(bA + 15051);
    vifA.enable = 1'b1;
    tickTo(bA + 15851);
    rstA = 1'b0;
    tickTo(bA + 15853);
    rstA = 1'b1;
    bA2 = cyc;
    pushExp(0, bA2 + 1, SIG_PE, 1, "A_rerun_pix_en");
    pushExp(0, bA2 + 1, SIG_H,  0, "A_rerun_h0");
    pushExp(0, bA2 + 2, SIG_H,  1, "A_rerun_h1");
    pushExp(0, bA2 + 4, SIG_H,  2, "A_rerun_h2");
    tickTo(bA2 + 10);

    // Small instance: 24 pixels x 19 lines, one clock per pixel, pixel index = cycles-1.
    pushResetState(1, cyc + 2, "B_reset");
    tickTo(cyc + 4);
    rstB = 1'b1;
    bB = cyc;
    pushExp(1, bB + 1,   SIG_PE, 1,  "B_first_pix_en");
    pushExp(1, bB + 1,   SIG_H,  0,  "B_h0");
    pushExp(1, bB + 1,   SIG_FS, 0,  "B_no_frame_start_on_release");
    pushExp(1, bB + 2,   SIG_H,  1,  "B_h1");
    pushExp(1, bB + 2,   SIG_PE, 1,  "B_pix_en_every_clk");
    pushExp(1, bB + 18,  SIG_HS, 1,  "B_hsync_h17");
    pushExp(1, bB + 19,  SIG_HS, 0,  "B_hsync_h18");
    pushExp(1, bB + 22,  SIG_HS, 0,  "B_hsync_h21");
    pushExp(1, bB + 23,  SIG_HS, 1,  "B_hsync_h22");
    pushExp(1, bB + 280, SIG_VO, 1,  "B_video_15_11");
    pushExp(1, bB + 280, SIG_X,  3,  "B_x_15_11");
    pushExp(1, bB + 280, SIG_Y,  2,  "B_y_15_11");
    pushExp(1, bB + 289, SIG_VO, 0,  "B_video_v12");
    pushExp(1, bB + 289, SIG_Y,  0,  "B_y_v12");
    pushExp(1, bB + 336, SIG_VS, 1,  "B_vsync_v13");
    pushExp(1, bB + 337, SIG_VS, 0,  "B_vsync_v14");
    pushExp(1, bB + 337, SIG_V,  14, "B_v14");
    pushExp(1, bB + 384, SIG_VS, 0,  "B_vsync_v15");
    pushExp(1, bB + 385, SIG_VS, 1,  "B_vsync_v16");
    pushExp(1, bB + 438, SIG_VO, 0,  "B_video_v18");
    pushExp(1, bB + 456, SIG_H,  23, "B_h_last");
    pushExp(1, bB + 456, SIG_V,  18, "B_v_last");
    pushExp(1, bB + 456, SIG_FS, 0,  "B_frame_start_before_wrap");
    pushExp(1, bB + 457, SIG_FS, 1,  "B_frame_start_first");
    pushExp(1, bB + 457, SIG_H,  0,  "B_h_frame_wrap");
    pushExp(1, bB + 457, SIG_V,  0,  "B_v_frame_wrap");
    pushExp(1, bB + 458, SIG_FS, 0,  "B_frame_start_one_clk");
    pushExp(1, bB + 912, SIG_FS, 0,  "B_frame_start_early");
    pushExp(1, bB + 913, SIG_FS, 1,  "B_frame_start_period");
    tickTo(bB + 920);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    applyStimulus();
    tickTo(cyc + 3);
    if (sb.size() != 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
